// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with hold, flush and load-use bubble insertion.
// Define ID_EX_PERF_CNT_EN to build the bubble/hold performance counters.
module id_ex_stage_reg #(
  parameter int              DATA_W       = 16,
  parameter int              OP_W         = 4,
  parameter int              RA_W         = 3,
  parameter logic [OP_W-1:0] LOAD_OP      = 4'b0010,
  parameter logic [OP_W-1:0] NOP_OP       = 4'b0000,
  parameter int              R0_HARDWIRED = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] imm,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [RA_W-1:0]   rd,
  input  logic              stall_in,
  input  logic              flush,
  output logic              out_valid,
  output logic [OP_W-1:0]   opcode_out,
  output logic [DATA_W-1:0] dataRFOut1,
  output logic [DATA_W-1:0] dataRFOut2,
  output logic [DATA_W-1:0] imm_out,
  output logic [RA_W-1:0]   rd_out,
  output logic              hazard_stall,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       hold_cnt
);

  logic dest_match;
  logic r0_exempt;
  logic take_bubble;
  logic take_hold;

  always_comb begin
    dest_match   = (rd_out == rs1) || (rd_out == rs2);
    r0_exempt    = (R0_HARDWIRED != 0) && (rd_out == '0);
    hazard_stall = out_valid && (opcode_out == LOAD_OP) && in_valid &&
                   dest_match && !r0_exempt && !flush;
    take_hold    = !flush && stall_in;
    take_bubble  = !flush && !stall_in && hazard_stall;
  end

  // Flush and hazard both collapse the stage into a bubble; stall simply holds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      opcode_out <= NOP_OP;
      dataRFOut1 <= '0;
      dataRFOut2 <= '0;
      imm_out    <= '0;
      rd_out     <= '0;
    end else if (flush || take_bubble) begin
      out_valid  <= 1'b0;
      opcode_out <= NOP_OP;
      dataRFOut1 <= '0;
      dataRFOut2 <= '0;
      imm_out    <= '0;
      rd_out     <= '0;
    end else if (!stall_in) begin
      out_valid <= in_valid;
      if (in_valid) begin
        opcode_out <= opcode;
        dataRFOut1 <= read_data1;
        dataRFOut2 <= read_data2;
        imm_out    <= imm;
        rd_out     <= rd;
      end else begin
        opcode_out <= NOP_OP;
        dataRFOut1 <= '0;
        dataRFOut2 <= '0;
        imm_out    <= '0;
        rd_out     <= '0;
      end
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] bubble_q;
  logic [15:0] hold_q;

  // Saturating event counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bubble_q <= '0;
      hold_q   <= '0;
    end else begin
      if (take_bubble && (bubble_q != 16'hFFFF))
        bubble_q <= bubble_q + 16'd1;
      if (take_hold && (hold_q != 16'hFFFF))
        hold_q <= hold_q + 16'd1;
    end
  end

  assign bubble_cnt = bubble_q;
  assign hold_cnt   = hold_q;
`else
  assign bubble_cnt = 16'h0000;
  assign hold_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: vector table plus reset and counter sequences.
module tb_id_ex_stage_reg;

  typedef struct {
    logic        in_valid;
    logic [3:0]  opcode;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [2:0]  rd;
    logic        stall;
    logic        flush;
    logic        exp_hazard;
    logic        exp_valid;
    logic [3:0]  exp_op;
    logic [15:0] exp_d1;
    logic [15:0] exp_d2;
    logic [15:0] exp_imm;
    logic [2:0]  exp_rd;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [3:0]  opcode;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic [15:0] imm;
  logic [2:0]  rs1;
  logic [2:0]  rs2;
  logic [2:0]  rd;
  logic        stall_in;
  logic        flush;
  logic        out_valid;
  logic [3:0]  opcode_out;
  logic [15:0] dataRFOut1;
  logic [15:0] dataRFOut2;
  logic [15:0] imm_out;
  logic [2:0]  rd_out;
  logic        hazard_stall;
  logic [15:0] bubble_cnt;
  logic [15:0] hold_cnt;

  int checks;
  int failures;
  vec_t vecs[$];

  id_ex_stage_reg dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .opcode(opcode),
    .read_data1(read_data1), .read_data2(read_data2), .imm(imm),
    .rs1(rs1), .rs2(rs2), .rd(rd), .stall_in(stall_in), .flush(flush),
    .out_valid(out_valid), .opcode_out(opcode_out), .dataRFOut1(dataRFOut1),
    .dataRFOut2(dataRFOut2), .imm_out(imm_out), .rd_out(rd_out),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid   = v.in_valid;
    opcode     = v.opcode;
    read_data1 = v.rd1;
    read_data2 = v.rd2;
    imm        = v.imm;
    rs1        = v.rs1;
    rs2        = v.rs2;
    rd         = v.rd;
    stall_in   = v.stall;
    flush      = v.flush;
  endtask

  task automatic checkOutput(input int idx, input logic ev, input logic [3:0] eop,
                             input logic [15:0] ed1, input logic [15:0] ed2,
                             input logic [15:0] eimm, input logic [2:0] erd);
    checkVal("out_valid", idx, 32'(out_valid), 32'(ev));
    checkVal("opcode_out", idx, 32'(opcode_out), 32'(eop));
    checkVal("dataRFOut1", idx, 32'(dataRFOut1), 32'(ed1));
    checkVal("dataRFOut2", idx, 32'(dataRFOut2), 32'(ed2));
    checkVal("imm_out", idx, 32'(imm_out), 32'(eimm));
    checkVal("rd_out", idx, 32'(rd_out), 32'(erd));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    // in_valid op rd1 rd2 imm rs1 rs2 rd stall flush | hazard valid op d1 d2 imm rd
    vecs.push_back('{1'b1,4'h1,16'h1234,16'hABCD,16'h0005,3'd1,3'd2,3'd4,1'b0,1'b0, 1'b0, 1'b1,4'h1,16'h1234,16'hABCD,16'h0005,3'd4});
    vecs.push_back('{1'b1,4'h2,16'h0011,16'h0022,16'h0008,3'd1,3'd2,3'd3,1'b0,1'b0, 1'b0, 1'b1,4'h2,16'h0011,16'h0022,16'h0008,3'd3});
    vecs.push_back('{1'b1,4'h1,16'h5555,16'h6666,16'h0001,3'd5,3'd3,3'd6,1'b0,1'b0, 1'b1, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h1,16'h5555,16'h6666,16'h0001,3'd5,3'd3,3'd6,1'b0,1'b0, 1'b0, 1'b1,4'h1,16'h5555,16'h6666,16'h0001,3'd6});
    vecs.push_back('{1'b1,4'h2,16'h0AAA,16'h0BBB,16'h0002,3'd0,3'd0,3'd0,1'b0,1'b0, 1'b0, 1'b1,4'h2,16'h0AAA,16'h0BBB,16'h0002,3'd0});
    vecs.push_back('{1'b1,4'h3,16'h0C0C,16'h0D0D,16'h0003,3'd0,3'd1,3'd2,1'b0,1'b0, 1'b0, 1'b1,4'h3,16'h0C0C,16'h0D0D,16'h0003,3'd2});
    vecs.push_back('{1'b0,4'h5,16'hFFFF,16'hEEEE,16'h0007,3'd0,3'd0,3'd7,1'b0,1'b0, 1'b0, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h2,16'h0101,16'h0202,16'h0004,3'd2,3'd3,3'd1,1'b0,1'b0, 1'b0, 1'b1,4'h2,16'h0101,16'h0202,16'h0004,3'd1});
    vecs.push_back('{1'b1,4'h2,16'h0303,16'h0404,16'h0005,3'd1,3'd0,3'd2,1'b0,1'b0, 1'b1, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h2,16'h0303,16'h0404,16'h0005,3'd1,3'd0,3'd2,1'b0,1'b0, 1'b0, 1'b1,4'h2,16'h0303,16'h0404,16'h0005,3'd2});
    vecs.push_back('{1'b1,4'h1,16'h0505,16'h0606,16'h0006,3'd2,3'd2,3'd5,1'b0,1'b0, 1'b1, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h1,16'h0505,16'h0606,16'h0006,3'd2,3'd2,3'd5,1'b0,1'b0, 1'b0, 1'b1,4'h1,16'h0505,16'h0606,16'h0006,3'd5});
    vecs.push_back('{1'b1,4'h4,16'h0707,16'h0808,16'h0009,3'd5,3'd0,3'd1,1'b0,1'b1, 1'b0, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd1,3'd1,3'd7,1'b0,1'b0, 1'b0, 1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd7});
    vecs.push_back('{1'b1,4'h1,16'hAAAA,16'hBBBB,16'h0001,3'd0,3'd0,3'd1,1'b1,1'b0, 1'b0, 1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd7});
    vecs.push_back('{1'b0,4'h2,16'hCCCC,16'hDDDD,16'h0002,3'd7,3'd7,3'd2,1'b1,1'b0, 1'b0, 1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd7});
    vecs.push_back('{1'b1,4'h3,16'h1212,16'h3434,16'h0003,3'd1,3'd2,3'd3,1'b1,1'b0, 1'b0, 1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd7});
    vecs.push_back('{1'b1,4'h4,16'h5656,16'h7878,16'h0004,3'd4,3'd5,3'd6,1'b1,1'b0, 1'b0, 1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd7});
    vecs.push_back('{1'b1,4'h5,16'h9A9A,16'hBCBC,16'h0005,3'd2,3'd3,3'd4,1'b1,1'b0, 1'b0, 1'b1,4'h6,16'h00FF,16'h1111,16'h0009,3'd7});
    vecs.push_back('{1'b1,4'h6,16'hDEDE,16'hF0F0,16'h0006,3'd1,3'd1,3'd1,1'b1,1'b1, 1'b0, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h7,16'h1357,16'h2468,16'h0007,3'd0,3'd0,3'd0,1'b1,1'b0, 1'b0, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h8,16'h0F0F,16'hF0F0,16'h0008,3'd3,3'd3,3'd3,1'b1,1'b0, 1'b0, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h2,16'h0123,16'h0456,16'h000A,3'd0,3'd0,3'd3,1'b0,1'b0, 1'b0, 1'b1,4'h2,16'h0123,16'h0456,16'h000A,3'd3});
    vecs.push_back('{1'b1,4'h1,16'h0777,16'h0888,16'h000B,3'd3,3'd4,3'd5,1'b1,1'b0, 1'b1, 1'b1,4'h2,16'h0123,16'h0456,16'h000A,3'd3});
    vecs.push_back('{1'b1,4'h1,16'h0777,16'h0888,16'h000B,3'd3,3'd4,3'd5,1'b0,1'b0, 1'b1, 1'b0,4'h0,16'h0000,16'h0000,16'h0000,3'd0});
    vecs.push_back('{1'b1,4'h1,16'h0777,16'h0888,16'h000B,3'd3,3'd4,3'd5,1'b0,1'b0, 1'b0, 1'b1,4'h1,16'h0777,16'h0888,16'h000B,3'd5});

    // Power-on reset with idle inputs.
    reset = 1'b1;
    applyStimulus('{1'b0,4'h0,16'h0,16'h0,16'h0,3'd0,3'd0,3'd0,1'b0,1'b0, 1'b0, 1'b0,4'h0,16'h0,16'h0,16'h0,3'd0});
    #1;
    checkOutput(-1, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 3'd0);
    checkVal("hazard_reset", -1, 32'(hazard_stall), 32'd0);
    checkVal("bubble_cnt_reset", -1, 32'(bubble_cnt), 32'd0);
    checkVal("hold_cnt_reset", -1, 32'(hold_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Table: hazard sampled before the edge, registers after it.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkVal("hazard_stall", i, 32'(hazard_stall), 32'(vecs[i].exp_hazard));
      @(posedge clock);
      #1;
      checkOutput(i, vecs[i].exp_valid, vecs[i].exp_op, vecs[i].exp_d1,
                  vecs[i].exp_d2, vecs[i].exp_imm, vecs[i].exp_rd);
    end

`ifdef ID_EX_PERF_CNT_EN
    checkVal("bubble_cnt", 100, 32'(bubble_cnt), 32'd4);
    checkVal("hold_cnt", 100, 32'(hold_cnt), 32'd8);
`else
    checkVal("bubble_cnt_tied", 100, 32'(bubble_cnt), 32'd0);
    checkVal("hold_cnt_tied", 100, 32'(hold_cnt), 32'd0);
`endif

    // Asynchronous reset pulse in the middle of a cycle, held across one edge.
    @(negedge clock);
    applyStimulus('{1'b1,4'h3,16'h00FF,16'h0100,16'h000C,3'd1,3'd2,3'd6,1'b0,1'b0, 1'b0, 1'b0,4'h0,16'h0,16'h0,16'h0,3'd0});
    @(posedge clock);
    #1;
    checkOutput(200, 1'b1, 4'h3, 16'h00FF, 16'h0100, 16'h000C, 3'd6);
    #2;
    reset = 1'b1;
    #1;
    checkOutput(201, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 3'd0);
    checkVal("bubble_cnt_async", 201, 32'(bubble_cnt), 32'd0);
    checkVal("hold_cnt_async", 201, 32'(hold_cnt), 32'd0);
    @(posedge clock);
    #1;
    checkOutput(202, 1'b0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 3'd0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus('{1'b1,4'h5,16'h4321,16'h8765,16'h000D,3'd0,3'd0,3'd2,1'b0,1'b0, 1'b0, 1'b0,4'h0,16'h0,16'h0,16'h0,3'd0});
    @(posedge clock);
    #1;
    checkOutput(203, 1'b1, 4'h5, 16'h4321, 16'h8765, 16'h000D, 3'd2);

`ifdef ID_EX_PERF_CNT_EN
    // Long hold run to reach and stay at counter saturation.
    @(negedge clock);
    stall_in = 1'b1;
    repeat (65537) @(posedge clock);
    #1;
    checkVal("hold_cnt_sat", 300, 32'(hold_cnt), 32'h0000FFFF);
    checkVal("bubble_cnt_sat", 300, 32'(bubble_cnt), 32'd0);
    checkOutput(300, 1'b1, 4'h5, 16'h4321, 16'h8765, 16'h000D, 3'd2);
    stall_in = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
